pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the combinational rotator.
- Rotates or shifts a DATA_WIDTH vector, left or right, by a per-transaction amount.
- Modes: rotate, logical shift, arithmetic shift.
- One registered mux level per bit of the amount.
- Valid/ready streaming interface on both sides with full back-pressure, for datapaths that need timing closure at wide widths.

Parameters:
- DATA_WIDTH, 8, width of data vector; must be >= 2.
- AMOUNT_WIDTH, CLOG2(DATA_WIDTH), width of shift/rotate amount; also the number of pipeline stages.

Ports:
- clock  input  1  clock, all logic on rising edge
- resetn  input  1  asynchronous active-low reset
- in_data  input  DATA_WIDTH  operand
- in_amount  input  AMOUNT_WIDTH  shift/rotate amount
- in_direction  input  1  0 = right, 1 = left
- in_mode  input  2  00 = rotate, 01 = logical shift, 10 = arithmetic shift, 11 = reserved (behaves as rotate)
- in_valid  input  1  input transaction valid
- in_ready  output  1  block can accept input this cycle
- out_data  output  DATA_WIDTH  result
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result

Behaviour:
- Reset: all stage valid bits 0; all stage data/control registers 0.
  - Hence out_valid = 0 and out_data = 0 during and after reset.
  - in_ready is 1 the first cycle after reset deasserts.
  - Assertion mid-operation immediately discards every in-flight transaction; no partial output.
- Input handshake:
  - Transfer occurs when in_valid && in_ready on a rising edge.
  - in_ready is combinational: stage 0 is empty, or stage 0 advances this cycle.
- Pipeline:
  - Stage i (0..AMOUNT_WIDTH-1) applies the operation by (2^i mod DATA_WIDTH) if amount bit i is 1, else passes data through.
  - Stage i registers its result together with amount, direction, mode and a valid bit.
  - Stage i advances when stage i+1 is empty or advancing. The last stage advances when out_ready is 1.
  - Bubbles collapse: an empty stage always accepts.
- Output:
  - out_valid / out_data are taken from the last stage register.
  - out_data is held stable while out_valid && !out_ready.
- Latency: exactly AMOUNT_WIDTH cycles from input transfer to out_valid when there is no back-pressure.
- Throughput: one transaction per cycle sustained.
- Ordering: results leave strictly in acceptance order. Capacity is AMOUNT_WIDTH transactions.
- Rotate: result is rotation by (amount mod DATA_WIDTH), in the selected direction.
- Logical shift:
  - Vacated bits are 0.
  - Amount >= DATA_WIDTH gives all zeros (non-power-of-two widths).
- Arithmetic shift:
  - Right: vacated bits take the original in_data MSB. Amount >= DATA_WIDTH gives all copies of the MSB.
  - Left: identical to logical left.
- Amount 0: result equals in_data in every mode and direction.
- Simultaneous output-accept and input-accept on a full pipeline is legal; no bubble is inserted.

Test Plan:
- W=8, in_data=0xB4, amount=3, right rotate -> out_data=0x96 exactly 3 cycles after accept. Same operand, left rotate -> 0xA5.
- W=8, in_data=0xB4, amount=2: arithmetic right -> 0xED; logical right -> 0x2D; logical left -> 0xD0; arithmetic left -> 0xD0; mode 11 right -> 0x2D rotate result (0x2D). Amount=0 in all modes -> 0xB4.
- W=8, out_ready=0, drive in_valid with 4 back-to-back items.
  - 3 are accepted; in_ready=0 on the 4th; out_valid=1 with out_data stable.
  - Raise out_ready: 4 results emerge in order, one per cycle; 4th accepted the same cycle the first leaves.
- W=8, random out_ready toggling with 1000 random transactions -> every result matches the reference model; no loss, duplication or reorder; in_ready never 1 when the pipeline is full and stalled.
- W=6 (AMOUNT_WIDTH=3), in_data=0x21:
  - rotate right by 7 -> 0x30;
  - logical right by 7 -> 0x00;
  - arithmetic right by 6 -> 0x3F.
- Assert resetn low for 1 cycle with 3 items in flight -> out_valid=0 and out_data=0 immediately. No stale result appears afterwards; the next accepted item completes with 3-cycle latency.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: rotate, logical shift or arithmetic shift of a DATA_WIDTH
// vector, left or right, by a per-transaction amount. One registered mux level per amount
// bit, with valid/ready handshakes and full back-pressure on both sides.
// DATA_WIDTH must be at least 2.
module pipelined_barrel_shifter #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned AMOUNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [AMOUNT_WIDTH-1:0] in_amount,
    input  logic                    in_direction,
    input  logic [1:0]              in_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Per-stage registers; index i holds the result of stage i.
    logic [AMOUNT_WIDTH-1:0]                   valid_q;
    logic [AMOUNT_WIDTH-1:0][DATA_WIDTH-1:0]   data_q;
    logic [AMOUNT_WIDTH-1:0][AMOUNT_WIDTH-1:0] amount_q;
    logic [AMOUNT_WIDTH-1:0]                   dir_q;
    logic [AMOUNT_WIDTH-1:0][1:0]              mode_q;

    // Stage inputs (stage 0 takes the input port, stage i takes stage i-1) and results.
    logic [AMOUNT_WIDTH-1:0]                   src_valid;
    logic [AMOUNT_WIDTH-1:0][DATA_WIDTH-1:0]   src_data;
    logic [AMOUNT_WIDTH-1:0][AMOUNT_WIDTH-1:0] src_amount;
    logic [AMOUNT_WIDTH-1:0]                   src_dir;
    logic [AMOUNT_WIDTH-1:0][1:0]              src_mode;
    logic [AMOUNT_WIDTH-1:0][DATA_WIDTH-1:0]   res_data;

    logic [AMOUNT_WIDTH-1:0] adv;
    logic                    adv_chain;

    // One operation by a fixed distance s. Arithmetic right keeps the current MSB, which
    // equals the original MSB because earlier right-shift stages never change it.
    function automatic logic [DATA_WIDTH-1:0] stage_op(input logic [DATA_WIDTH-1:0] d,
                                                        input logic left,
                                                        input logic [1:0] mode,
                                                        input int unsigned s);
        logic [DATA_WIDTH-1:0] r;
        r = d;
        if (s != 0) begin
            case (mode)
                2'b01:   r = left ? (d << s) : (d >> s);
                2'b10:   r = left ? (d << s) : $unsigned($signed(d) >>> s);
                default: r = left ? ((d << s) | (d >> (DATA_WIDTH - s)))
                                  : ((d >> s) | (d << (DATA_WIDTH - s)));
            endcase
        end
        return r;
    endfunction

    // Route stage inputs and apply each stage's conditional operation.
    always_comb begin
        src_valid  = '0;
        src_data   = '0;
        src_amount = '0;
        src_dir    = '0;
        src_mode   = '0;
        res_data   = '0;
        src_valid[0]  = in_valid;
        src_data[0]   = in_data;
        src_amount[0] = in_amount;
        src_dir[0]    = in_direction;
        src_mode[0]   = in_mode;
        for (int i = 1; i < int'(AMOUNT_WIDTH); i++) begin
            src_valid[i]  = valid_q[i-1];
            src_data[i]   = data_q[i-1];
            src_amount[i] = amount_q[i-1];
            src_dir[i]    = dir_q[i-1];
            src_mode[i]   = mode_q[i-1];
        end
        for (int i = 0; i < int'(AMOUNT_WIDTH); i++) begin
            res_data[i] = src_amount[i][i]
                        ? stage_op(src_data[i], src_dir[i], src_mode[i],
                                   (32'd1 << i) % DATA_WIDTH)
                        : src_data[i];
        end
    end

    // Advance chain from the output back: a stage moves if it is empty or its successor moves.
    always_comb begin
        adv       = '0;
        adv_chain = out_ready;
        for (int i = int'(AMOUNT_WIDTH) - 1; i >= 0; i--) begin
            adv[i]    = !valid_q[i] || adv_chain;
            adv_chain = adv[i];
        end
    end

    // Stage registers; reset discards every in-flight transaction.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= '0;
            data_q   <= '0;
            amount_q <= '0;
            dir_q    <= '0;
            mode_q   <= '0;
        end else begin
            for (int i = 0; i < int'(AMOUNT_WIDTH); i++) begin
                if (adv[i]) begin
                    valid_q[i]  <= src_valid[i];
                    data_q[i]   <= res_data[i];
                    amount_q[i] <= src_amount[i];
                    dir_q[i]    <= src_dir[i];
                    mode_q[i]   <= src_mode[i];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[AMOUNT_WIDTH-1];
    assign out_data  = data_q[AMOUNT_WIDTH-1];

    // Low amount bits of later stages and the last stage's control are not consumed.
    logic unused_ctrl;
    assign unused_ctrl = ^{src_amount, amount_q[AMOUNT_WIDTH-1], dir_q[AMOUNT_WIDTH-1],
                           mode_q[AMOUNT_WIDTH-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (W=8 and W=6 instances).
module tb_pipelined_barrel_shifter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn;

    logic [7:0] in_data8;
    logic [2:0] in_amount8;
    logic       in_direction8;
    logic [1:0] in_mode8;
    logic       in_valid8, in_ready8;
    logic [7:0] out_data8;
    logic       out_valid8, out_ready8;

    logic [5:0] in_data6;
    logic [2:0] in_amount6;
    logic       in_direction6;
    logic [1:0] in_mode6;
    logic       in_valid6, in_ready6;
    logic [5:0] out_data6;
    logic       out_valid6, out_ready6;

    int n_cmp;
    int n_err;

    logic [7:0] sb8[$];
    logic [5:0] sb6[$];

    pipelined_barrel_shifter #(.DATA_WIDTH(8)) dut8 (
        .clock(clock), .resetn(resetn),
        .in_data(in_data8), .in_amount(in_amount8), .in_direction(in_direction8),
        .in_mode(in_mode8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8)
    );

    pipelined_barrel_shifter #(.DATA_WIDTH(6)) dut6 (
        .clock(clock), .resetn(resetn),
        .in_data(in_data6), .in_amount(in_amount6), .in_direction(in_direction6),
        .in_mode(in_mode6), .in_valid(in_valid6), .in_ready(in_ready6),
        .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready6)
    );

    // Bit-by-bit reference: output bit k picks its source bit directly.
    function automatic logic [7:0] model(input logic [7:0] d, input int a, input logic left,
                                         input logic [1:0] m, input int w);
        logic [7:0] r;
        logic       msb;
        int         src;
        r   = '0;
        msb = d[w-1];
        for (int k = 0; k < w; k++) begin
            if (m == 2'b00 || m == 2'b11) begin
                src  = left ? ((k - (a % w)) + w) % w : (k + a) % w;
                r[k] = d[src];
            end else begin
                src = left ? k - a : k + a;
                if (src >= 0 && src < w) r[k] = d[src];
                else r[k] = (m == 2'b10 && !left) ? msb : 1'b0;
            end
        end
        return r;
    endfunction

    // Drive one cycle on the W=8 instance (entered at a falling edge), sample mid-cycle.
    task automatic step8(input logic v, input logic [7:0] d, input logic [2:0] a,
                         input logic left, input logic [1:0] m, input logic ordy,
                         output logic rdy, output logic ov, output logic [7:0] od);
        in_valid8 = v; in_data8 = d; in_amount8 = a; in_direction8 = left;
        in_mode8 = m; out_ready8 = ordy;
        #1;
        rdy = in_ready8; ov = out_valid8; od = out_data8;
        @(negedge clock);
    endtask

    task automatic step6(input logic v, input logic [5:0] d, input logic [2:0] a,
                         input logic left, input logic [1:0] m, input logic ordy,
                         output logic rdy, output logic ov, output logic [5:0] od);
        in_valid6 = v; in_data6 = d; in_amount6 = a; in_direction6 = left;
        in_mode6 = m; out_ready6 = ordy;
        #1;
        rdy = in_ready6; ov = out_valid6; od = out_data6;
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_cmp += 4;
        if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL rst_valid8 got %b want 0", out_valid8); end
        if (out_data8 !== 8'h00) begin n_err++; $display("FAIL rst_data8 got %h want 00", out_data8); end
        if (out_valid6 !== 1'b0) begin n_err++; $display("FAIL rst_valid6 got %b want 0", out_valid6); end
        if (out_data6 !== 6'h00) begin n_err++; $display("FAIL rst_data6 got %h want 00", out_data6); end
        resetn = 1'b1;
        #1;
        n_cmp += 2;
        if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL rst_ready8 got %b want 1", in_ready8); end
        if (in_ready6 !== 1'b1) begin n_err++; $display("FAIL rst_ready6 got %b want 1", in_ready6); end
        @(negedge clock);
    endtask

    task automatic test_rotate();
        logic [7:0] exp_d [2];
        logic       dir   [2];
        logic       rdy, ov, seen;
        logic [7:0] od;
        exp_d[0] = 8'h96; dir[0] = 1'b0;
        exp_d[1] = 8'hA5; dir[1] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            step8(1'b1, 8'hB4, 3'd3, dir[t], 2'b00, 1'b1, rdy, ov, od);
            n_cmp++;
            if (rdy !== 1'b1) begin n_err++; $display("FAIL rot_accept got %b want 1", rdy); end
            sb8.push_back(exp_d[t]);
            seen = 1'b0;
            for (int c = 1; c <= 8 && !seen; c++) begin
                step8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, rdy, ov, od);
                if (ov) begin
                    seen = 1'b1;
                    n_cmp += 2;
                    if (c != 3) begin n_err++; $display("FAIL rot_latency got %0d want 3", c); end
                    if (od !== sb8[0]) begin
                        n_err++; $display("FAIL rot_data got %h want %h", od, sb8[0]);
                    end
                    void'(sb8.pop_front());
                end
            end
            if (!seen) begin
                n_cmp++; n_err++; sb8.delete();
                $display("FAIL rot_timeout got no output want %h", exp_d[t]);
            end
        end
    endtask

    task automatic test_modes();
        logic [7:0] te [13];
        logic [2:0] ta [13];
        logic       tl [13];
        logic [1:0] tm [13];
        logic       rdy, ov;
        logic [7:0] od;
        int         i, cyc;
        ta[0] = 3'd2; tl[0] = 1'b0; tm[0] = 2'b10; te[0] = 8'hED;
        ta[1] = 3'd2; tl[1] = 1'b0; tm[1] = 2'b01; te[1] = 8'h2D;
        ta[2] = 3'd2; tl[2] = 1'b1; tm[2] = 2'b01; te[2] = 8'hD0;
        ta[3] = 3'd2; tl[3] = 1'b1; tm[3] = 2'b10; te[3] = 8'hD0;
        ta[4] = 3'd2; tl[4] = 1'b0; tm[4] = 2'b11; te[4] = 8'h2D;
        for (int j = 0; j < 8; j++) begin
            ta[5+j] = 3'd0; tl[5+j] = j[0]; tm[5+j] = 2'(j >> 1); te[5+j] = 8'hB4;
        end
        i = 0;
        cyc = 0;
        while ((i < 13 || sb8.size() != 0) && cyc < 100) begin
            if (i < 13) step8(1'b1, 8'hB4, ta[i], tl[i], tm[i], 1'b1, rdy, ov, od);
            else step8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, rdy, ov, od);
            if (ov) begin
                n_cmp++;
                if (sb8.size() == 0) begin
                    n_err++; $display("FAIL modes_extra got %h want none", od);
                end else begin
                    if (od !== sb8[0]) begin
                        n_err++; $display("FAIL modes_data got %h want %h", od, sb8[0]);
                    end
                    void'(sb8.pop_front());
                end
            end
            if (i < 13 && rdy) begin sb8.push_back(te[i]); i++; end
            cyc++;
        end
        n_cmp++;
        if (sb8.size() != 0 || i != 13) begin
            n_err++; $display("FAIL modes_drain got %0d left want 0", sb8.size() + 13 - i);
            sb8.delete();
        end
    endtask

    task automatic test_width6();
        logic [5:0] te [3];
        logic [2:0] ta [3];
        logic [1:0] tm [3];
        logic       rdy, ov;
        logic [5:0] od;
        int         i, cyc;
        ta[0] = 3'd7; tm[0] = 2'b00; te[0] = 6'h30;
        ta[1] = 3'd7; tm[1] = 2'b01; te[1] = 6'h00;
        ta[2] = 3'd6; tm[2] = 2'b10; te[2] = 6'h3F;
        i = 0;
        cyc = 0;
        while ((i < 3 || sb6.size() != 0) && cyc < 50) begin
            if (i < 3) step6(1'b1, 6'h21, ta[i], 1'b0, tm[i], 1'b1, rdy, ov, od);
            else step6(1'b0, 6'h00, 3'd0, 1'b0, 2'b00, 1'b1, rdy, ov, od);
            if (ov) begin
                n_cmp++;
                if (sb6.size() == 0) begin
                    n_err++; $display("FAIL w6_extra got %h want none", od);
                end else begin
                    if (od !== sb6[0]) begin
                        n_err++; $display("FAIL w6_data got %h want %h", od, sb6[0]);
                    end
                    void'(sb6.pop_front());
                end
            end
            if (i < 3 && rdy) begin sb6.push_back(te[i]); i++; end
            cyc++;
        end
        n_cmp++;
        if (sb6.size() != 0 || i != 3) begin
            n_err++; $display("FAIL w6_drain got %0d left want 0", sb6.size() + 3 - i);
            sb6.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [4];
        logic [2:0] a [4];
        logic       l [4];
        logic [1:0] m [4];
        logic       rdy, ov;
        logic [7:0] od;
        for (int k = 0; k < 4; k++) begin
            d[k] = 8'($urandom); a[k] = 3'($urandom); l[k] = 1'($urandom); m[k] = 2'($urandom);
        end
        for (int k = 0; k < 3; k++) begin
            step8(1'b1, d[k], a[k], l[k], m[k], 1'b0, rdy, ov, od);
            n_cmp++;
            if (rdy !== 1'b1) begin n_err++; $display("FAIL b2b_fill got %b want 1", rdy); end
            sb8.push_back(model(d[k], int'(a[k]), l[k], m[k], 8));
        end
        for (int s = 0; s < 3; s++) begin
            step8(1'b1, d[3], a[3], l[3], m[3], 1'b0, rdy, ov, od);
            n_cmp += 3;
            if (rdy !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready got %b want 0", rdy); end
            if (ov !== 1'b1) begin n_err++; $display("FAIL b2b_stall_valid got %b want 1", ov); end
            if (od !== sb8[0]) begin
                n_err++; $display("FAIL b2b_hold got %h want %h", od, sb8[0]);
            end
        end
        step8(1'b1, d[3], a[3], l[3], m[3], 1'b1, rdy, ov, od);
        n_cmp += 3;
        if (rdy !== 1'b1) begin n_err++; $display("FAIL b2b_same_cycle got %b want 1", rdy); end
        if (ov !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid got %b want 1", ov); end
        if (od !== sb8[0]) begin n_err++; $display("FAIL b2b_first got %h want %h", od, sb8[0]); end
        void'(sb8.pop_front());
        sb8.push_back(model(d[3], int'(a[3]), l[3], m[3], 8));
        for (int s = 0; s < 3; s++) begin
            step8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, rdy, ov, od);
            n_cmp += 2;
            if (ov !== 1'b1) begin n_err++; $display("FAIL b2b_drain_valid got %b want 1", ov); end
            if (od !== sb8[0]) begin
                n_err++; $display("FAIL b2b_order got %h want %h", od, sb8[0]);
            end
            void'(sb8.pop_front());
        end
    endtask

    task automatic test_random();
        logic       v, rdy, ov, ordy;
        logic [7:0] d, od;
        logic [2:0] a;
        logic       l;
        logic [1:0] m;
        int         sent, cyc, occ;
        v = 1'b0; d = '0; a = '0; l = 1'b0; m = '0;
        sent = 0;
        cyc = 0;
        while ((sent < 1000 || sb8.size() != 0) && cyc < 20000) begin
            if (!v && sent < 1000 && $urandom_range(0, 3) != 0) begin
                v = 1'b1;
                d = 8'($urandom); a = 3'($urandom); l = 1'($urandom); m = 2'($urandom);
            end
            ordy = ($urandom_range(0, 9) < 6);
            occ  = sb8.size();
            step8(v, d, a, l, m, ordy, rdy, ov, od);
            if (occ == 3 && !ordy) begin
                n_cmp++;
                if (rdy !== 1'b0) begin n_err++; $display("FAIL rnd_full_ready got %b want 0", rdy); end
            end
            if (ov && ordy) begin
                n_cmp++;
                if (sb8.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra got %h want none", od);
                end else begin
                    if (od !== sb8[0]) begin
                        n_err++; $display("FAIL rnd_data got %h want %h", od, sb8[0]);
                    end
                    void'(sb8.pop_front());
                end
            end
            if (v && rdy) begin
                sb8.push_back(model(d, int'(a), l, m, 8));
                sent++;
                v = 1'b0;
            end
            cyc++;
        end
        n_cmp++;
        if (sb8.size() != 0 || sent != 1000) begin
            n_err++; $display("FAIL rnd_complete got %0d sent %0d left want 1000 sent 0 left",
                              sent, sb8.size());
            sb8.delete();
        end
    endtask

    task automatic test_midreset();
        logic       rdy, ov, seen;
        logic [7:0] od;
        for (int k = 0; k < 3; k++) begin
            step8(1'b1, 8'(8'h11 * (k + 1)), 3'(k + 1), 1'b0, 2'b00, 1'b0, rdy, ov, od);
            n_cmp++;
            if (rdy !== 1'b1) begin n_err++; $display("FAIL mrst_fill got %b want 1", rdy); end
        end
        in_valid8 = 1'b0;
        resetn = 1'b0;
        #1;
        n_cmp += 2;
        if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b want 0", out_valid8); end
        if (out_data8 !== 8'h00) begin n_err++; $display("FAIL mrst_data got %h want 00", out_data8); end
        sb8.delete();
        @(negedge clock);
        resetn = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, rdy, ov, od);
            n_cmp++;
            if (ov !== 1'b0) begin n_err++; $display("FAIL mrst_stale got %b want 0", ov); end
        end
        step8(1'b1, 8'h5C, 3'd1, 1'b1, 2'b01, 1'b1, rdy, ov, od);
        n_cmp++;
        if (rdy !== 1'b1) begin n_err++; $display("FAIL mrst_accept got %b want 1", rdy); end
        sb8.push_back(8'hB8);
        seen = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            step8(1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 1'b1, rdy, ov, od);
            if (ov) begin
                seen = 1'b1;
                n_cmp += 2;
                if (c != 3) begin n_err++; $display("FAIL mrst_latency got %0d want 3", c); end
                if (od !== sb8[0]) begin
                    n_err++; $display("FAIL mrst_data_after got %h want %h", od, sb8[0]);
                end
                void'(sb8.pop_front());
            end
        end
        if (!seen) begin
            n_cmp++; n_err++; sb8.delete();
            $display("FAIL mrst_timeout got no output want b8");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetn = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; in_amount8 = '0; in_direction8 = 1'b0;
        in_mode8 = '0; out_ready8 = 1'b1;
        in_valid6 = 1'b0; in_data6 = '0; in_amount6 = '0; in_direction6 = 1'b0;
        in_mode6 = '0; out_ready6 = 1'b1;
        test_reset();
        test_rotate();
        test_modes();
        test_width6();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
